// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver: 2-flop synchroniser, bit FSM, and a holding buffer read via one CSR.
// Define UART_RX_FIFO_EN to replace the single holding register with a 4-entry FIFO.
package csr_uart_rx_pkg;
    typedef enum logic [1:0] {CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2, CSR_RC = 2'd3} csr_op_t;
endpackage

module csr_uart_rx
    import csr_uart_rx_pkg::*;
#(
    parameter logic [11:0] CsrAddr  = 12'h051,
    parameter int          ClkFreq  = 12_000_000,
    parameter int          BaudRate = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_enable,
    input  logic [11:0] csr_addr,
    input  logic [4:0]  rs1_zimm,
    input  logic [31:0] rs1_data,
    input  csr_op_t     csr_op,
    input  logic        rx,
    output logic [31:0] out,
    output logic        irq
);
    localparam int Div  = ClkFreq / BaudRate;
    localparam int Half = Div / 2;
    localparam int CntW = $clog2(Div);

    if (Div < 4) begin : g_div_check
        $error("csr_uart_rx: ClkFreq/BaudRate must be at least 4");
    end

    logic unused_ok;
    assign unused_ok = ^{rs1_zimm, rs1_data, csr_op};

    logic [1:0] sync_q;
    logic       rxs;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx};
    end
    assign rxs = sync_q[1];

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} state_t;

    state_t          state_q;
    logic [CntW-1:0] cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic            push_q;
    logic            fe_set_q;

    // push_q/fe_set_q are registered so the buffer updates one edge after the stop sample.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            push_q   <= 1'b0;
            fe_set_q <= 1'b0;
        end else begin
            push_q   <= 1'b0;
            fe_set_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q <= S_START;
                        cnt_q   <= '0;
                    end
                end
                S_START: begin
                    if (cnt_q == CntW'(Half - 1)) begin
                        cnt_q   <= '0;
                        bit_q   <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == CntW'(Div - 1)) begin
                        cnt_q   <= '0;
                        shift_q <= {rxs, shift_q[7:1]};
                        if (bit_q == 3'd7) state_q <= S_STOP;
                        else               bit_q   <= bit_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == CntW'(Div - 1)) begin
                        cnt_q <= '0;
                        if (rxs) begin
                            push_q  <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            fe_set_q <= 1'b1;
                            state_q  <= S_WAIT_HIGH;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                S_WAIT_HIGH: begin
                    if (rxs) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic       consume;
    logic       pop;
    logic       push_ok;
    logic       has_data;
    logic [7:0] head;

    assign consume = csr_enable && (csr_addr == CsrAddr);

`ifdef UART_RX_FIFO_EN
    logic [7:0] mem_q [4];
    logic [1:0] rptr_q, wptr_q;
    logic [2:0] count_q;

    assign has_data = (count_q != 3'd0);
    assign pop      = consume && has_data;
    assign push_ok  = push_q && ((count_q != 3'd4) || pop);
    assign head     = has_data ? mem_q[rptr_q] : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= '0;
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) rptr_q <= rptr_q + 2'd1;
            if (push_ok) begin
                mem_q[wptr_q] <= shift_q;
                wptr_q        <= wptr_q + 2'd1;
            end
            count_q <= count_q + {2'b00, push_ok} - {2'b00, pop};
        end
    end
`else
    logic       valid_q;
    logic [7:0] data_q;

    assign has_data = valid_q;
    assign pop      = consume && valid_q;
    assign push_ok  = push_q && (!valid_q || consume);
    assign head     = valid_q ? data_q : 8'h00;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (push_ok) begin
            valid_q <= 1'b1;
            data_q  <= shift_q;
        end else if (pop) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end
    end
`endif

    logic ovr_q, fe_q;

    // Clear on consume first; the later set statements win in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= 1'b0;
            fe_q  <= 1'b0;
        end else begin
            if (consume) begin
                ovr_q <= 1'b0;
                fe_q  <= 1'b0;
            end
            if (push_q && !push_ok) ovr_q <= 1'b1;
            if (fe_set_q)           fe_q  <= 1'b1;
        end
    end

    assign out = {21'b0, fe_q, ovr_q, has_data, head};
    assign irq = has_data;

endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed bench for csr_uart_rx with Div = 16; expected CSR words are hand-computed.
module tb_csr_uart_rx;
    import csr_uart_rx_pkg::*;

    localparam logic [11:0] ADDR = 12'h051;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        csr_enable = 1'b0;
    logic [11:0] csr_addr = 12'h000;
    logic [4:0]  rs1_zimm = 5'd0;
    logic [31:0] rs1_data = 32'd0;
    csr_op_t     csr_op = CSR_RS;
    logic        rx = 1'b1;
    logic [31:0] out;
    logic        irq;

    int n_chk = 0;
    int n_pass = 0;

    csr_uart_rx #(.CsrAddr(ADDR), .ClkFreq(16), .BaudRate(1)) dut (
        .clk(clk), .reset(reset), .csr_enable(csr_enable), .csr_addr(csr_addr),
        .rs1_zimm(rs1_zimm), .rs1_data(rs1_data), .csr_op(csr_op), .rx(rx),
        .out(out), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Start bit goes low just after the first edge; each bit lasts 16 cycles.
    task automatic send(input logic [7:0] b, input logic stop);
        @(posedge clk); #1 rx = 1'b0;
        repeat (16) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (16) @(posedge clk);
        end
        #1 rx = stop;
        repeat (16) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic access(input logic [11:0] a);
        @(posedge clk); #1 csr_enable = 1'b1; csr_addr = a;
        @(posedge clk); #1 csr_enable = 1'b0; csr_addr = 12'h000;
    endtask

    initial begin
        #2;
        @(negedge clk);
        chk("reset_out", out, 32'h0);
        chk("reset_irq", {31'b0, irq}, 32'h0);
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        // Basic byte with valid-latency check around the stop sample edge
        fork
            send(8'hA5, 1'b1);
            begin
                repeat (156) @(posedge clk);
                @(negedge clk); chk("lat_irq_lo", {31'b0, irq}, 32'h0);
                @(negedge clk); chk("lat_irq_hi", {31'b0, irq}, 32'h1);
            end
        join
        @(negedge clk); chk("a5_out", out, 32'h000001A5);
        access(12'h052);
        @(negedge clk); chk("wrong_addr", out, 32'h000001A5);
        access(ADDR);
        @(negedge clk); chk("a5_consumed", out, 32'h0);
        chk("a5_irq", {31'b0, irq}, 32'h0);

        // Short glitch must not start a frame
        @(posedge clk); #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        @(negedge clk); chk("glitch", out, 32'h0);

        // Framing error followed by a long break
        send(8'h3C, 1'b0);
        #1 rx = 1'b0;
        repeat (640) @(posedge clk);
        #1 rx = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk); chk("break_fe", out, 32'h00000400);
        send(8'h11, 1'b1);
        @(negedge clk); chk("after_break", out, 32'h00000511);
        access(ADDR);
        @(negedge clk); chk("break_clr", out, 32'h0);

        // Overrun
`ifdef UART_RX_FIFO_EN
        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        @(negedge clk); chk("ovr", out, 32'h00000301);
        access(ADDR); @(negedge clk); chk("fifo_rd2", out, 32'h00000102);
        access(ADDR); @(negedge clk); chk("fifo_rd3", out, 32'h00000103);
        access(ADDR); @(negedge clk); chk("fifo_rd4", out, 32'h00000104);
        access(ADDR); @(negedge clk); chk("fifo_empty", out, 32'h0);
`else
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        @(negedge clk); chk("ovr", out, 32'h00000301);
        access(ADDR);
        @(negedge clk); chk("ovr_clr", out, 32'h0);
`endif

        // Consume on the exact push cycle into a full buffer
`ifdef UART_RX_FIFO_EN
        for (int i = 0; i < 4; i++) send(8'h33 + 8'(i), 1'b1);
`else
        send(8'h33, 1'b1);
`endif
        fork
            send(8'h7E, 1'b1);
            begin
                repeat (156) @(posedge clk);
                #1 csr_enable = 1'b1; csr_addr = ADDR;
                @(posedge clk); #1 csr_enable = 1'b0; csr_addr = 12'h000;
                @(negedge clk);
`ifdef UART_RX_FIFO_EN
                chk("push_pop", out, 32'h00000134);
`else
                chk("push_pop", out, 32'h0000017E);
`endif
            end
        join
`ifdef UART_RX_FIFO_EN
        repeat (4) access(ADDR);
`else
        access(ADDR);
`endif
        @(negedge clk); chk("push_pop_clr", out, 32'h0);

        // Reset during data bit 4 of 0xFF, with a byte already buffered
        send(8'h0F, 1'b1);
        @(negedge clk); chk("pre_reset", out, 32'h0000010F);
        fork
            send(8'hFF, 1'b1);
            begin
                repeat (89) @(posedge clk);
                #3 reset = 1'b1;
                #1;
                chk("midrst_out", out, 32'h0);
                chk("midrst_irq", {31'b0, irq}, 32'h0);
                repeat (2) @(posedge clk);
                #1 reset = 1'b0;
            end
        join
        repeat (20) @(posedge clk);
        @(negedge clk); chk("partial_lost", out, 32'h0);
        send(8'h55, 1'b1);
        @(negedge clk); chk("post_rst_55", out, 32'h00000155);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
